// File: rtl/event_injector_pkg.sv
// Shared CPU constants for the event injector.
// Opcode, register indices, FSM states, ADDI word builder.
package event_injector_pkg;

  localparam logic [4:0]  ADDI      = 5'd5;
  localparam logic [4:0]  FRAME_REG = 5'd28;
  localparam logic [4:0]  JUMP_REG  = 5'd29;
  localparam logic [4:0]  ZERO_REG  = 5'd0;
  localparam logic [16:0] INJ_IMM   = 17'd1;
  localparam logic [7:0]  DROP_MAX  = 8'd255;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } inj_state_e;

  // addi rd,$0,1 : {op[31:27], rd[26:22], rs[21:17], imm[16:0]}
  function automatic logic [31:0] addi_word(
    input logic [4:0] rd
  );
    return {ADDI, rd, ZERO_REG, INJ_IMM};
  endfunction

endpackage

// File: rtl/event_injector_if.sv
// Fetch-side bus between CPU fetch stage and the injector.
// master: fetch/stim side; slave: injector side.
interface event_injector_if;

  logic        frame_rdy;
  logic        jump_btn;
  logic [31:0] imem_instr;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] instr_out;
  logic        pc_hold;
  logic        inject_valid;
  logic [7:0]  drop_count;

  modport master (
    output frame_rdy,
    output jump_btn,
    output imem_instr,
    output stall_in,
    output flush_in,
    input  instr_out,
    input  pc_hold,
    input  inject_valid,
    input  drop_count
  );

  modport slave (
    input  frame_rdy,
    input  jump_btn,
    input  imem_instr,
    input  stall_in,
    input  flush_in,
    output instr_out,
    output pc_hold,
    output inject_valid,
    output drop_count
  );

endinterface

// File: rtl/event_injector_btn_sync_edge.sv
// Button synchroniser (2 flops) plus rising-edge detector.
// Ports: clock, reset, btn_i (async level), rise_o (1-cycle pulse).
module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic       s1_q;
  logic       s2_q;
  logic       edge_q;
  logic [1:0] fill_q;
  logic       armed_q;

  // fill_q[1] marks s2_q as holding a real sample rather than
  // the reset zero; arming needs a genuine low so a button held
  // through reset cannot fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      edge_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      edge_q  <= s2_q;
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && !s2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise_o = s2_q & ~edge_q & armed_q;

endmodule

// File: rtl/event_injector.sv
// Injects addi $29/$28 words into fetch on jump/frame events.
// Ports: clock, reset, bus (slave: fetch inputs, injected outputs).
module event_injector
  import event_injector_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  event_injector_if.slave  bus
);

  inj_state_e  state_q;
  inj_state_e  state_d;
  logic        jmp_pend_q;
  logic        jmp_pend_d;
  logic        frm_pend_q;
  logic        frm_pend_d;
  logic [7:0]  drop_q;
  logic [7:0]  drop_d;

  logic        jmp_ev;
  logic        frm_ev;
  logic        slot;
  logic        inj_jmp;
  logic        inj_frm;
  logic        jmp_drop;
  logic        frm_drop;
  logic [1:0]  n_drop;
  logic [8:0]  drop_sum;

  btn_sync_edge u_btn (
    .clock  (clock),
    .reset  (reset),
    .btn_i  (bus.jump_btn),
    .rise_o (jmp_ev)
  );

  // frame_rdy is already in this clock domain
  assign frm_ev = bus.frame_rdy;

  always_comb begin
    slot = !reset
        && (state_q == IDLE)
        && !bus.stall_in
        && !bus.flush_in;
    inj_jmp = slot && jmp_pend_q;
    inj_frm = slot && !jmp_pend_q && frm_pend_q;

    // new event wins over a same-cycle clear
    jmp_pend_d = (jmp_pend_q & ~inj_jmp) | jmp_ev;
    frm_pend_d = (frm_pend_q & ~inj_frm) | frm_ev;

    jmp_drop = jmp_ev & jmp_pend_q & ~inj_jmp;
    frm_drop = frm_ev & frm_pend_q & ~inj_frm;
    n_drop   = {1'b0, jmp_drop} + {1'b0, frm_drop};
    drop_sum = {1'b0, drop_q} + {7'd0, n_drop};
    if (drop_sum > {1'b0, DROP_MAX}) begin
      drop_d = DROP_MAX;
    end else begin
      drop_d = drop_sum[7:0];
    end

    // GAP always returns to IDLE; injection only leaves IDLE
    if (inj_jmp || inj_frm) begin
      state_d = GAP;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      jmp_pend_q <= 1'b0;
      frm_pend_q <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      jmp_pend_q <= jmp_pend_d;
      frm_pend_q <= frm_pend_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    bus.instr_out    = bus.imem_instr;
    bus.pc_hold      = 1'b0;
    bus.inject_valid = 1'b0;
    unique case (1'b1)
      inj_jmp: begin
        bus.instr_out    = addi_word(JUMP_REG);
        bus.pc_hold      = 1'b1;
        bus.inject_valid = 1'b1;
      end
      inj_frm: begin
        bus.instr_out    = addi_word(FRAME_REG);
        bus.pc_hold      = 1'b1;
        bus.inject_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.drop_count = drop_q;

endmodule

// File: doc/event_injector.md
EVENT_INJECTOR -- requirements
Module: event_injector

Interface
REQ-001 SHALL declare clock  in  1  system clock; every register updates on its rising edge.
REQ-002 SHALL declare reset  in  1  synchronous, active-high reset.
REQ-003 SHALL declare frame_rdy  in  1  one-cycle pulse from the VGA timing block, synchronous to clock.
REQ-004 SHALL declare jump_btn  in  1  raw asynchronous jump button level.
REQ-005 SHALL declare imem_instr  in  32  instruction read from instruction memory at the current PC.
REQ-006 SHALL declare stall_in  in  1  hazard-unit fetch stall.
REQ-007 SHALL declare flush_in  in  1  taken-branch/jump flush of the F/D register.
REQ-008 SHALL declare instr_out  out  32  instruction presented to the F/D latch.
REQ-009 SHALL declare pc_hold  out  1  high means PC does not advance this cycle.
REQ-010 SHALL declare inject_valid  out  1  high means instr_out is an injected instruction.
REQ-011 SHALL declare drop_count  out  8  saturating count of coalesced events.

Function
REQ-012 SHALL pass jump_btn through a 2-flop synchroniser, then a rising-edge detector; the detector pulse is the jump event.
REQ-013 SHALL use frame_rdy directly as the frame event, with no synchroniser.
REQ-014 SHALL keep two pending bits, jmp_pend and frm_pend, each set on the clock edge after its event is sampled high.
REQ-015 SHALL define the slot as (state==IDLE) && !stall_in && !flush_in.
REQ-016 SHALL inject when the slot is open and any pending bit is set; jmp_pend has priority over frm_pend.
REQ-017 SHALL drive injected jump as addi $29,$0,1: opcode 00101, rd 29, rs 0, imm 17'd1.
REQ-018 SHALL drive injected frame as addi $28,$0,1: opcode 00101, rd 28, rs 0, imm 17'd1.
REQ-019 SHALL, in an injection cycle, drive instr_out=injected word, pc_hold=1 and inject_valid=1, and clear the served pending bit at the end of that cycle.
REQ-020 SHALL otherwise drive instr_out=imem_instr, pc_hold=0 and inject_valid=0, all combinationally.
REQ-021 SHALL implement FSM states IDLE and GAP: IDLE->GAP on injection; GAP->IDLE unconditionally; no injection in GAP, which lets the held PC fetch once.
REQ-022 SHALL make event-to-injection latency 1 cycle when the slot is open; while the slot is closed, pending holds indefinitely.
REQ-023 SHALL, on an event whose pending bit is already set and not cleared that cycle, keep the bit set and increment drop_count, saturating at 255.
REQ-024 SHALL, on an event arriving in the same cycle its pending bit is cleared by injection, leave the bit set with no drop counted.
REQ-025 SHALL set both pending bits independently when both events arrive together; jump is served first and frame two cycles later, after GAP.
REQ-026 SHALL never inject while flush_in=1; pending is retained.

Reset
REQ-027 SHALL clear, on reset=1 at a clock edge, the synchroniser flops, edge register, both pending bits and drop_count, and set state=IDLE.
REQ-028 SHALL, during reset, drive instr_out=imem_instr, pc_hold=0 and inject_valid=0.
REQ-029 SHALL discard any in-flight event when reset is asserted mid-operation; a button held high through reset produces no event until it is released and pressed again.

Structure
REQ-030 SHALL place opcode ADDI=5'd5, register indices FRAME_REG=28 and JUMP_REG=29, and the FSM state encodings in the shared CPU constants include.
REQ-031 SHALL implement synchroniser plus edge detect as one sub-module, btn_sync_edge, instantiated once.

Verification
REQ-032 SHALL check: frame_rdy pulse at cycle 10, no stall -> cycle 11 instr_out=0x2F000001, pc_hold=1; cycle 12 passthrough.
REQ-033 SHALL check: jump_btn rises, then frame_rdy pulses in the cycle jmp_pend sets -> 0x2F400001 injected first, GAP, then 0x2F000001.
REQ-034 SHALL check: stall_in high for 5 cycles with frm_pend set -> no injection during stall; injection in the first cycle stall_in=0.
REQ-035 SHALL check: three frame_rdy pulses while stalled -> a single injection and drop_count=2; 300 pulses while stalled -> drop_count=255.
REQ-036 SHALL check: flush_in=1 in a would-be injection cycle -> passthrough, pending kept, injection next open slot.
REQ-037 SHALL check: reset asserted with both pending bits set -> next cycle pending=0, drop_count=0, IDLE, no injection.
